// File: rtl/irq_ctrl.sv
// irq_ctrl: bus-mapped interrupt controller for the CPU INT input.
// Synchronised edge/level sources, pending latch, mask, global enable.
module irq_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             en,
  input  logic             we,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             int_out,
  output logic [4:0]       int_id
);

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic             gie_q, gie_d;
  logic             int_out_q, int_out_d;
  logic [4:0]       int_id_q, int_id_d;

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] set;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] active;
  logic             wr;
  logic             unused_wdata;

  assign s      = sync_q[SYNC_STAGES-1];
  assign set    = (s & ~prev_q & ~mode_q) | (s & mode_q);
  assign active = pend_q & mask_q;
  assign wr     = en & we;

  assign unused_wdata = ^wdata[31:N_SRC];

  always_comb begin
    clr    = '0;
    mask_d = mask_q;
    mode_d = mode_q;
    gie_d  = gie_q;
    if (wr) begin
      case (addr)
        2'd0: clr    = wdata[N_SRC-1:0];
        2'd1: mask_d = wdata[N_SRC-1:0];
        2'd2: mode_d = wdata[N_SRC-1:0];
        2'd3: gie_d  = wdata[0];
        default: ;
      endcase
    end
    // a new request in the same cycle survives the clear
    pend_d = (pend_q & ~clr) | set;
  end

  always_comb begin
    int_id_d = 5'h1F;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) int_id_d = 5'(i);
    end
    if (!gie_q) int_id_d = 5'h1F;
    int_out_d = gie_q & (|active);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= irq_src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= '0;
      pend_q    <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
      gie_q     <= 1'b0;
      int_out_q <= 1'b0;
      int_id_q  <= 5'h1F;
    end else begin
      prev_q    <= s;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      gie_q     <= gie_d;
      int_out_q <= int_out_d;
      int_id_q  <= int_id_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = 32'(pend_q);
      2'd1: rdata = 32'(mask_q);
      2'd2: rdata = 32'(mode_q);
      2'd3: begin
        rdata[12:8] = int_id_q;
        rdata[0]    = gie_q;
      end
      default: ;
    endcase
  end

  assign int_out = int_out_q;
  assign int_id  = int_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plan plus randomized run against a
// cycle-level reference model built from sample history.
module tb_irq_ctrl;
  localparam int N = 8;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  irq_src = '0;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          int_out;
  logic [4:0]    int_id;

  int n_chk = 0;
  int n_fail = 0;

  logic [N-1:0] m_hist [$];
  logic [N-1:0] m_pend, m_mask, m_mode;
  logic         m_gie, m_out;
  logic [4:0]   m_id;

  irq_ctrl #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .en(en), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .int_out(int_out), .int_id(int_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    for (int i = 0; i <= S; i++) m_hist.push_front('0);
    m_pend = '0; m_mask = '0; m_mode = '0;
    m_gie = 1'b0; m_out = 1'b0; m_id = 5'h1F;
  endtask

  // One clock edge; the model consumes the inputs present at the edge.
  task automatic step();
    logic [N-1:0] src_c, s, p, set, act, clr;
    logic rst_c, wr_c;
    logic [1:0] a_c;
    logic [31:0] d_c;
    src_c = irq_src; rst_c = rst; wr_c = en & we;
    a_c = addr; d_c = wdata;
    @(posedge clk);
    if (rst_c) begin
      model_reset();
    end else begin
      s   = m_hist[S-1];
      p   = m_hist[S];
      set = (s & ~p & ~m_mode) | (s & m_mode);
      act = m_pend & m_mask;
      m_out = m_gie && (act != 0);
      m_id = 5'h1F;
      if (m_out)
        for (int i = N - 1; i >= 0; i--)
          if (act[i]) m_id = 5'(i);
      clr = (wr_c && a_c == 2'd0) ? d_c[N-1:0] : '0;
      m_pend = (m_pend & ~clr) | set;
      if (wr_c && a_c == 2'd1) m_mask = d_c[N-1:0];
      if (wr_c && a_c == 2'd2) m_mode = d_c[N-1:0];
      if (wr_c && a_c == 2'd3) m_gie = d_c[0];
      m_hist.push_front(src_c);
      void'(m_hist.pop_back());
    end
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    en = 1'b1; we = 1'b1; addr = a; wdata = d;
    step();
    en = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] d;
    chk({tag, ".int_out"}, 32'(int_out), 32'(m_out));
    chk({tag, ".int_id"}, 32'(int_id), 32'(m_id));
    rd(2'd0, d); chk({tag, ".pend"}, d, 32'(m_pend));
    rd(2'd1, d); chk({tag, ".mask"}, d, 32'(m_mask));
    rd(2'd2, d); chk({tag, ".mode"}, d, 32'(m_mode));
    rd(2'd3, d); chk({tag, ".ctrl"}, d, (32'(m_id) << 8) | 32'(m_gie));
  endtask

  initial begin
    logic [31:0] d;
    model_reset();

    rst = 1'b1; steps(2); rst = 1'b0; step();
    rd(2'd0, d); chk("rst.pend", d, 32'h0);
    rd(2'd1, d); chk("rst.mask", d, 32'h0);
    rd(2'd2, d); chk("rst.mode", d, 32'h0);
    rd(2'd3, d); chk("rst.ctrl", d, 32'h00001F00);
    chk("rst.int_out", 32'(int_out), 32'h0);

    wr(2'd1, 32'h4); wr(2'd3, 32'h1);
    irq_src = 8'h04;
    steps(3);
    rd(2'd0, d); chk("edge.pend_e3", d, 32'h4);
    chk("edge.out_e3", 32'(int_out), 32'h0);
    step();
    chk("edge.out_e4", 32'(int_out), 32'h1);
    chk("edge.id_e4", 32'(int_id), 32'h2);
    wr(2'd0, 32'h4);
    chk("w1c.out_e1", 32'(int_out), 32'h1);
    step();
    chk("w1c.out_e2", 32'(int_out), 32'h0);
    chk("w1c.id_e2", 32'(int_id), 32'h1F);
    steps(3);
    rd(2'd0, d); chk("edge.no_retrig", d, 32'h0);
    irq_src = '0; steps(4);

    wr(2'd1, 32'h0A);
    irq_src = 8'h0A; steps(2); irq_src = '0; steps(3);
    chk("prio.id1", 32'(int_id), 32'h1);
    wr(2'd0, 32'h2); step();
    chk("prio.id3", 32'(int_id), 32'h3);
    chk("prio.out3", 32'(int_out), 32'h1);
    wr(2'd0, 32'h8); step();
    chk("prio.id_none", 32'(int_id), 32'h1F);
    chk("prio.out_none", 32'(int_out), 32'h0);

    wr(2'd1, 32'h0);
    irq_src = 8'h01; steps(2); irq_src = '0; steps(3);
    rd(2'd0, d); chk("mask.pend", d, 32'h1);
    chk("mask.out_masked", 32'(int_out), 32'h0);
    wr(2'd1, 32'h1); step();
    chk("mask.out_unmask", 32'(int_out), 32'h1);
    wr(2'd3, 32'h0); step();
    chk("gie.out_off", 32'(int_out), 32'h0);
    chk("gie.id_off", 32'(int_id), 32'h1F);
    wr(2'd3, 32'h1); step();
    chk("gie.out_on", 32'(int_out), 32'h1);
    wr(2'd0, 32'h1); step();

    wr(2'd2, 32'h20); wr(2'd1, 32'h20);
    irq_src = 8'h20; steps(3);
    wr(2'd0, 32'h20);
    rd(2'd0, d); chk("lvl.w1c_high", d, 32'h20);
    step();
    rd(2'd0, d); chk("lvl.reset_next", d, 32'h20);
    irq_src = '0; steps(3);
    wr(2'd0, 32'h20); step();
    rd(2'd0, d); chk("lvl.cleared", d, 32'h0);
    wr(2'd2, 32'h0);

    wr(2'd1, 32'h1);
    irq_src = 8'h01; steps(2);
    wr(2'd0, 32'h1);
    rd(2'd0, d); chk("setwins.pend", d, 32'h1);
    step();
    chk("setwins.out", 32'(int_out), 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst.out", 32'(int_out), 32'h0);
    chk("midrst.id", 32'(int_id), 32'h1F);
    rd(2'd3, d); chk("midrst.ctrl", d, 32'h00001F00);
    irq_src = '0; steps(4);
    chk_model("sync");

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ N'($urandom);
      rst   = ($urandom_range(0, 149) == 0);
      en    = ($urandom_range(0, 1) == 1);
      we    = ($urandom_range(0, 2) == 0);
      addr  = 2'($urandom);
      wdata = $urandom;
      step();
      rst = 1'b0; en = 1'b0; we = 1'b0;
      chk_model("rand");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
